// File: rtl/fill_rect_data_gen_engine_p.sv
// Fill-rect data generator: on a start strobe it streams one write beat per
// (pixel, colour channel) of a wid x hgt rectangle to the memory arbiter,
// in solid-fill or outline-only mode. Beats advance only on a real transfer.
module fill_rect_data_gen_engine_p #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int LANES        = 4,
  parameter int CH_BITS      = 4,
  parameter int NUM_CH       = 3,
  parameter int PIX_PER_LANE = 2,
  parameter int ROW_STRIDE   = 240
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start_strobe,
  input  logic [ADDR_W-1:0]         i_init_addr,
  input  logic [15:0]               i_cmd_wid,
  input  logic [15:0]               i_cmd_hgt,
  input  logic                      i_cmd_mode,
  input  logic [NUM_CH*CH_BITS-1:0] i_cmd_ch_val,
  output logic                      o_decode_start_strobe,
  output logic                      o_busy,
  output logic                      o_done_strobe,
  output logic                      o_arb_out_rts,
  input  logic                      i_arb_in_rtr,
  output logic [ADDR_W-1:0]         o_arb_out_addr,
  output logic [DATA_W-1:0]         o_arb_out_data,
  output logic [LANES-1:0]          o_arb_out_wben,
  output logic                      o_arb_out_op
);

  localparam int LANE_W   = DATA_W / LANES;
  localparam int PPW      = LANES * PIX_PER_LANE;
  localparam int LOG2_PPL = $clog2(PIX_PER_LANE);
  localparam int LOG2_PPW = $clog2(PPW);
  localparam int C_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int REP      = LANE_W / CH_BITS;

  // S_ZERO is the accept cycle of an empty rectangle; S_FINISH carries done.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRIVE  = 2'd1;
  localparam logic [1:0] S_ZERO   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  // v * NUM_CH built from shifted adds of the set bits of NUM_CH
  function automatic logic [ADDR_W-1:0] times_num_ch(input logic [15:0] v);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int b = 0; b < 31; b++) begin
      if (((NUM_CH >> b) & 1) != 0) begin
        acc = acc + ADDR_W'(32'(v) << b);
      end else begin
        acc = acc;
      end
    end
    return acc;
  endfunction

  logic [1:0]                r_state;
  logic [15:0]               r_wid;
  logic [15:0]               r_hgt;
  logic                      r_mode;
  logic [NUM_CH*CH_BITS-1:0] r_ch_val;
  logic [15:0]               r_x;
  logic [15:0]               r_y;
  logic [C_W-1:0]            r_c;
  logic [ADDR_W-1:0]         r_row_base;
  logic [ADDR_W-1:0]         r_word_off;
  logic [ADDR_W-1:0]         r_jump_off;

  logic                      w_xfc;
  logic                      w_last_beat;
  logic [15:0]               w_nx;
  logic [15:0]               w_ny;
  logic [C_W-1:0]            w_nc;
  logic [ADDR_W-1:0]         w_nrow;
  logic [ADDR_W-1:0]         w_noff;

  logic [15:0]               w_sel_x;
  logic [C_W-1:0]            w_sel_c;
  logic [ADDR_W-1:0]         w_sel_row;
  logic [ADDR_W-1:0]         w_sel_off;
  logic [NUM_CH*CH_BITS-1:0] w_sel_chv;
  logic [CH_BITS-1:0]        w_ch;
  logic [LANE_W-1:0]         w_rep;
  logic [15:0]               w_lane;
  logic [ADDR_W-1:0]         w_beat_addr;
  logic [DATA_W-1:0]         w_beat_data;
  logic [LANES-1:0]          w_beat_wben;

  assign w_xfc        = o_arb_out_rts & i_arb_in_rtr;
  assign o_arb_out_op = 1'b0;

  // Next position in the walk: channel, then column (with outline jump), then row
  always_comb begin
    w_nx        = r_x;
    w_ny        = r_y;
    w_nc        = r_c;
    w_nrow      = r_row_base;
    w_noff      = r_word_off;
    w_last_beat = 1'b0;
    if (r_c != C_W'(NUM_CH - 1)) begin
      w_nc = r_c + C_W'(1);
    end else begin
      w_nc = '0;
      if (r_x != r_wid - 16'd1) begin
        if (r_mode && (r_y != 16'd0) && (r_y != r_hgt - 16'd1) && (r_x == 16'd0)) begin
          // interior outline row: skip straight to the right edge
          w_nx   = r_wid - 16'd1;
          w_noff = r_jump_off;
        end else begin
          w_nx = r_x + 16'd1;
          if (&r_x[LOG2_PPW-1:0]) begin
            w_noff = r_word_off + ADDR_W'(NUM_CH);
          end else begin
            w_noff = r_word_off;
          end
        end
      end else if (r_y != r_hgt - 16'd1) begin
        w_ny   = r_y + 16'd1;
        w_nx   = 16'd0;
        w_noff = '0;
        w_nrow = r_row_base + ADDR_W'(ROW_STRIDE);
      end else begin
        w_last_beat = 1'b1;
      end
    end
  end

  // Format the beat to present next: first beat on accept, else the advanced position
  always_comb begin
    if (r_state == S_IDLE) begin
      w_sel_x   = 16'd0;
      w_sel_c   = '0;
      w_sel_row = i_init_addr;
      w_sel_off = '0;
      w_sel_chv = i_cmd_ch_val;
    end else begin
      w_sel_x   = w_nx;
      w_sel_c   = w_nc;
      w_sel_row = w_nrow;
      w_sel_off = w_noff;
      w_sel_chv = r_ch_val;
    end
    w_ch = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      w_ch = (w_sel_c == C_W'(ch)) ? w_sel_chv[ch*CH_BITS +: CH_BITS] : w_ch;
    end
    w_rep       = {REP{w_ch}};
    w_lane      = (w_sel_x >> LOG2_PPL) & 16'(LANES - 1);
    w_beat_data = '0;
    w_beat_wben = '0;
    for (int l = 0; l < LANES; l++) begin
      w_beat_data[l*LANE_W +: LANE_W] = (w_lane == 16'(l)) ? w_rep : '0;
      w_beat_wben[l]                  = (w_lane == 16'(l));
    end
    w_beat_addr = w_sel_row + w_sel_off + ADDR_W'(w_sel_c);
  end

  // Control FSM, walk counters and registered arbiter outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state               <= S_IDLE;
      r_wid                 <= '0;
      r_hgt                 <= '0;
      r_mode                <= 1'b0;
      r_ch_val              <= '0;
      r_x                   <= '0;
      r_y                   <= '0;
      r_c                   <= '0;
      r_row_base            <= '0;
      r_word_off            <= '0;
      r_jump_off            <= '0;
      o_decode_start_strobe <= 1'b0;
      o_busy                <= 1'b0;
      o_done_strobe         <= 1'b0;
      o_arb_out_rts         <= 1'b0;
      o_arb_out_addr        <= '0;
      o_arb_out_data        <= '0;
      o_arb_out_wben        <= '0;
    end else begin
      o_decode_start_strobe <= 1'b0;
      o_done_strobe         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start_strobe) begin
            r_wid                 <= i_cmd_wid;
            r_hgt                 <= i_cmd_hgt;
            r_mode                <= i_cmd_mode;
            r_ch_val              <= i_cmd_ch_val;
            r_x                   <= '0;
            r_y                   <= '0;
            r_c                   <= '0;
            r_row_base            <= i_init_addr;
            r_word_off            <= '0;
            r_jump_off            <= times_num_ch((i_cmd_wid - 16'd1) >> LOG2_PPW);
            o_decode_start_strobe <= 1'b1;
            o_busy                <= 1'b1;
            if ((i_cmd_wid == 16'd0) || (i_cmd_hgt == 16'd0)) begin
              r_state <= S_ZERO;
            end else begin
              r_state        <= S_DRIVE;
              o_arb_out_rts  <= 1'b1;
              o_arb_out_addr <= w_beat_addr;
              o_arb_out_data <= w_beat_data;
              o_arb_out_wben <= w_beat_wben;
            end
          end
        end
        S_DRIVE: begin
          if (w_xfc) begin
            if (w_last_beat) begin
              o_arb_out_rts <= 1'b0;
              o_busy        <= 1'b0;
              o_done_strobe <= 1'b1;
              r_state       <= S_FINISH;
            end else begin
              r_x            <= w_nx;
              r_y            <= w_ny;
              r_c            <= w_nc;
              r_row_base     <= w_nrow;
              r_word_off     <= w_noff;
              o_arb_out_addr <= w_beat_addr;
              o_arb_out_data <= w_beat_data;
              o_arb_out_wben <= w_beat_wben;
            end
          end
        end
        S_ZERO: begin
          o_busy        <= 1'b0;
          o_done_strobe <= 1'b1;
          r_state       <= S_FINISH;
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state       <= S_IDLE;
          o_busy        <= 1'b0;
          o_arb_out_rts <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fill_rect_data_gen_engine_p.sv
// Self-checking bench for fill_rect_data_gen_engine_p: a rectangle-walk model
// produces the expected beat list, a monitor compares every transfer and
// stall, and directed tests check strobes, timing, wrap and reset abort.
module tb_fill_rect_data_gen_engine_p;

  localparam int LANES      = 4;
  localparam int LANE_W     = 8;
  localparam int CH_BITS    = 4;
  localparam int NUM_CH     = 3;
  localparam int PPL        = 2;
  localparam int PPW        = 8;
  localparam int ROW_STRIDE = 240;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  wben;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] init_addr;
  logic [15:0] wid;
  logic [15:0] hgt;
  logic        mode;
  logic [11:0] chv;
  logic        rtr;
  logic        dec, busy, done, rts, op;
  logic [15:0] addr;
  logic [31:0] data;
  logic [3:0]  wben;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          beat_cnt = 0;
  int          last_xfc_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] s_addr;
  logic [31:0] s_data;
  logic [3:0]  s_wben;

  fill_rect_data_gen_engine_p dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_start_strobe        (start),
    .i_init_addr           (init_addr),
    .i_cmd_wid             (wid),
    .i_cmd_hgt             (hgt),
    .i_cmd_mode            (mode),
    .i_cmd_ch_val          (chv),
    .o_decode_start_strobe (dec),
    .o_busy                (busy),
    .o_done_strobe         (done),
    .o_arb_out_rts         (rts),
    .i_arb_in_rtr          (rtr),
    .o_arb_out_addr        (addr),
    .o_arb_out_data        (data),
    .o_arb_out_wben        (wben),
    .o_arb_out_op          (op)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One beat straight from the rectangle arithmetic
  function automatic beat_t model_beat(input int ia, input int x, input int y, input int c, input logic [11:0] cv);
    beat_t b;
    int lane;
    int ch;
    int rep;
    lane = (x / PPL) % LANES;
    ch   = (int'(cv) >> (c * CH_BITS)) & 15;
    rep  = 0;
    for (int k = 0; k < LANE_W / CH_BITS; k++) rep = rep | (ch << (k * CH_BITS));
    b.addr = 16'((ia + y * ROW_STRIDE + (x / PPW) * NUM_CH + c) % 65536);
    b.data = 32'(rep) << (lane * LANE_W);
    b.wben = 4'(1 << lane);
    return b;
  endfunction

  task automatic build_model(input int ia, input int w, input int h, input bit m, input logic [11:0] cv);
    exp_q.delete();
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (!m || y == 0 || y == h - 1 || x == 0 || x == w - 1)
          for (int c = 0; c < NUM_CH; c++) exp_q.push_back(model_beat(ia, x, y, c, cv));
  endtask

  function automatic logic pat_val(input int pat, input int n);
    return (pat == 0) ? 1'b1 : ((n % 3) == 0);
  endfunction

  // Monitor: every transfer against the model, every stall for stability
  always @(negedge clk) begin
    beat_t eb;
    if (!rst) begin
      check("op_const", op, 0);
      if (prev_stall) begin
        check("stall_rts", rts, 1);
        check("stall_addr", addr, s_addr);
        check("stall_data", data, s_data);
        check("stall_wben", wben, s_wben);
      end
      if (rts && rtr) begin
        beat_cnt++;
        last_xfc_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got addr 0x%0h, expected no beat", addr);
        end else begin
          eb = exp_q.pop_front();
          check("beat_addr", addr, eb.addr);
          check("beat_data", data, eb.data);
          check("beat_wben", wben, eb.wben);
        end
      end
      prev_stall = rts && !rtr;
      s_addr = addr;
      s_data = data;
      s_wben = wben;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_cmd(input int ia, input int w, input int h, input bit m, input logic [11:0] cv,
                         input int pat, input int exp_total, input bit poke);
    int  acc_cyc;
    bit  done_seen;
    beat_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; init_addr = 16'(ia); wid = 16'(w); hgt = 16'(h); mode = m; chv = cv;
    @(posedge clk); #1;
    start = 1'b0; rtr = pat_val(pat, 0);
    init_addr = 16'($urandom); wid = 16'($urandom); hgt = 16'($urandom); mode = ~m; chv = 12'($urandom);
    @(negedge clk);
    check("decode_strobe", dec, 1);
    check("busy_on_accept", busy, 1);
    check("first_rts", rts, (exp_total != 0));
    acc_cyc = cyc;
    done_seen = 1'b0;
    for (int n = 0; n < 2000 && !done_seen; n++) begin
      @(posedge clk); #1;
      rtr = pat_val(pat, n + 1);
      start = poke && (n == 0);
      if (poke && n == 0) begin
        wid = 16'd2; hgt = 16'd1;
      end
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_strobe, expected one within budget");
    end else begin
      check("done_timing", cyc, (exp_total == 0) ? acc_cyc + 1 : last_xfc_cyc + 1);
      check("busy_at_done", busy, 0);
      check("rts_at_done", rts, 0);
      check("model_drained", exp_q.size(), 0);
      check("beat_count", beat_cnt, exp_total);
    end
    @(posedge clk); #1;
    start = 1'b0; rtr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle_rts", rts, 0);
      check("idle_decode", dec, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; init_addr = '0; wid = '0; hgt = '0; mode = 1'b0; chv = '0; rtr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rts", rts, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dec", dec, 0);
    check("rst_addr", addr, 0);
    check("rst_data", data, 0);
    check("rst_wben", wben, 0);
    @(posedge clk); #1; rst = 1'b0;

    // solid 2x1, rtr high
    build_model(16'h0100, 2, 1, 0, 12'hF5A);
    check("pin1_size", exp_q.size(), 6);
    check("pin1_a0", exp_q[0].addr, 16'h0100);
    check("pin1_d0", exp_q[0].data, 32'h0000_00AA);
    check("pin1_w0", exp_q[0].wben, 4'h1);
    check("pin1_a4", exp_q[4].addr, 16'h0101);
    check("pin1_d5", exp_q[5].data, 32'h0000_00FF);
    run_cmd(16'h0100, 2, 1, 0, 12'hF5A, 0, 6, 0);

    // solid 3x2: lane 1 at x=2, next row base
    build_model(16'h0100, 3, 2, 0, 12'hF5A);
    check("pin2_size", exp_q.size(), 18);
    check("pin2_a6", exp_q[6].addr, 16'h0100);
    check("pin2_w6", exp_q[6].wben, 4'h2);
    check("pin2_d6", exp_q[6].data, 32'h0000_AA00);
    check("pin2_a9", exp_q[9].addr, 16'h01F0);
    run_cmd(16'h0100, 3, 2, 0, 12'hF5A, 0, 18, 0);

    // same as first with stalling arbiter
    build_model(16'h0100, 2, 1, 0, 12'hF5A);
    run_cmd(16'h0100, 2, 1, 0, 12'hF5A, 1, 6, 0);

    // outline 4x3
    build_model(16'h0000, 4, 3, 1, 12'hF5A);
    check("pin4_size", exp_q.size(), 30);
    check("pin4_a12", exp_q[12].addr, 16'h00F0);
    check("pin4_w12", exp_q[12].wben, 4'h1);
    check("pin4_a15", exp_q[15].addr, 16'h00F0);
    check("pin4_w15", exp_q[15].wben, 4'h2);
    run_cmd(16'h0000, 4, 3, 1, 12'hF5A, 0, 30, 0);

    // outline 12x4 with stalls: jump crosses a word boundary
    build_model(16'h0200, 12, 4, 1, 12'h3C7);
    check("pin5_size", exp_q.size(), 3 * (2 * 12 + 2 * 2));
    run_cmd(16'h0200, 12, 4, 1, 12'h3C7, 1, 84, 0);

    // empty rectangle, start poked while busy
    build_model(16'h0000, 0, 5, 0, 12'hF5A);
    run_cmd(16'h0000, 0, 5, 0, 12'hF5A, 0, 0, 1);

    // address wrap
    build_model(16'hFFFE, 1, 1, 0, 12'hF5A);
    check("pin6_a0", exp_q[0].addr, 16'hFFFE);
    check("pin6_a2", exp_q[2].addr, 16'h0000);
    run_cmd(16'hFFFE, 1, 1, 0, 12'hF5A, 0, 3, 0);

    // reset after one transfer aborts the command
    build_model(16'hFFFE, 1, 1, 0, 12'hF5A);
    beat_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; init_addr = 16'hFFFE; wid = 16'd1; hgt = 16'd1; mode = 1'b0; chv = 12'hF5A; rtr = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; rtr = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; rtr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_rts", rts, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_beats", beat_cnt, 1);
    @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_no_rts", rts, 0);
    end
    exp_q.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
